// File: rtl/ifft4_stream.sv
// ifft4_stream: streaming 4-point inverse DFT, natural-order bins in, natural-order samples out
module ifft4_stream #(
  parameter int N = 16,
  parameter int Q = 8,
  parameter bit SCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r,
  input  logic [N-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r,
  output logic [N-1:0] out_i,
  output logic         out_last
);
  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;
  localparam int W = N + 3;
  localparam logic signed [W-1:0] MAXV = W'((1 <<< (N - 1)) - 1);
  localparam logic signed [W-1:0] MINV = -MAXV - 1;
  localparam logic signed [W-1:0] TWO = 2;
  if (Q < 0 || Q >= N) begin : g_q_check
    $error("Q must lie in [0, N)");
  end
  state_t state, state_nx;
  logic [1:0] idx_in, idx_out;
  logic [N-1:0] bin_r [4];
  logic [N-1:0] bin_i [4];
  logic [N-1:0] buf_r [4];
  logic [N-1:0] buf_i [4];
  logic [N-1:0] y_r [4];
  logic [N-1:0] y_i [4];
  logic signed [W-1:0] a0_r, a0_i, a1_r, a1_i, b0_r, b0_i, b1_r, b1_i;
  function automatic logic signed [W-1:0] ext(input logic [N-1:0] v);
    return W'($signed(v));
  endfunction
  // Scaled results can exceed N bits only in one extreme corner, so clamping is kept in both modes
  function automatic logic [N-1:0] fit(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = SCALE ? (v + TWO) >>> 2 : v;
    return s > MAXV ? MAXV[N-1:0] : s < MINV ? MINV[N-1:0] : s[N-1:0];
  endfunction
  always_comb begin
    a0_r = ext(bin_r[0]) + ext(bin_r[2]);
    a0_i = ext(bin_i[0]) + ext(bin_i[2]);
    a1_r = ext(bin_r[0]) - ext(bin_r[2]);
    a1_i = ext(bin_i[0]) - ext(bin_i[2]);
    b0_r = ext(bin_r[1]) + ext(bin_r[3]);
    b0_i = ext(bin_i[1]) + ext(bin_i[3]);
    b1_r = ext(bin_r[1]) - ext(bin_r[3]);
    b1_i = ext(bin_i[1]) - ext(bin_i[3]);
    y_r[0] = fit(a0_r + b0_r);
    y_i[0] = fit(a0_i + b0_i);
    y_r[1] = fit(a1_r - b1_i);
    y_i[1] = fit(a1_i + b1_r);
    y_r[2] = fit(a0_r - b0_r);
    y_i[2] = fit(a0_i - b0_i);
    y_r[3] = fit(a1_r + b1_i);
    y_i[3] = fit(a1_i - b1_r);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = (in_valid && idx_in == 2'd3) ? CALC : LOAD;
      CALC:    state_nx = DRAIN;
      DRAIN:   state_nx = (out_ready && idx_out == 2'd3) ? LOAD : DRAIN;
      default: state_nx = LOAD;
    endcase
  end
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign out_last  = out_valid && idx_out == 2'd3;
  assign out_r     = out_valid ? buf_r[idx_out] : '0;
  assign out_i     = out_valid ? buf_i[idx_out] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_in  <= '0;
      idx_out <= '0;
    end else begin
      if (in_valid && in_ready) begin
        bin_r[idx_in] <= in_r;
        bin_i[idx_in] <= in_i;
        idx_in <= idx_in + 2'd1;
      end
      if (state == CALC) begin
        buf_r   <= y_r;
        buf_i   <= y_i;
        idx_out <= '0;
      end else if (out_valid && out_ready) begin
        idx_out <= idx_out + 2'd1;
      end
    end
  end
endmodule
